exec_sequencer: RTL
===================

# exec_sequencer

Fetch/decode/write-back controller that sits directly upstream and downstream of the ALU. It fetches 8-bit instructions from program memory and holds the accumulator and a 16-entry register file. It presents opcode/acc/data_reg to the ALU and writes acc_out/ext/cb back into architectural state. Together with the ALU it forms the complete single-issue, multi-cycle core.

## Interface
- PC_W, 8: program-counter / instruction-address width
- RF_DEPTH, 16: general registers, indexed by instruction bits [3:0]
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  PC_W  fetch address (= pc)
- imem_req  out  1  fetch request, held until imem_valid
- imem_data  in  8  instruction byte, valid when imem_valid
- imem_valid  in  1  fetch completion; ignored while imem_req=0
- opcode  out  8  to ALU
- acc_to_alu  out  8  accumulator value to ALU acc input
- data_reg  out  8  operand to ALU
- acc_out  in  8  ALU result
- ext  in  8  ALU extension byte (MUL high byte etc.)
- cb  in  1  ALU carry/borrow/compare flag
- acc  out  8  architectural accumulator
- ext_reg  out  8  latched ext
- cb_flag  out  1  latched cb
- pc  out  PC_W  program counter
- halted  out  1  high in HALT

## Operation
- Encoding: upper nibble 0001 ADD, 0010 SUB, 0011 MUL, 0101 AND, 0110 XOR, 0111 CMP (operand Rn, n=[3:0]); 1000 MOV Rn<-acc; 1001 MOV acc<-Rn; 0000_0001 LSL, 0000_0010 LSR, 0000_0110 INC, 0000_0111 DEC (no operand); 0000_0000 NOP; 1111_1111 HLT; all other codes are treated as NOP.
- States: FETCH, DECODE, EXEC, WB, HALT.
- FETCH: imem_req=1, imem_addr=pc. On imem_valid: IR<=imem_data, pc<=pc+1 (wraps mod 2^PC_W), go to DECODE. Otherwise stay.
- DECODE:
  - ALU op -> EXEC.
  - MOV Rn<-acc: writes RF[n]; MOV acc<-Rn: writes acc; both -> FETCH.
  - NOP/illegal -> FETCH.
  - HLT -> HALT.
- EXEC: opcode=IR, acc_to_alu=acc. data_reg=RF[IR[3:0]] for upper-nibble ops, 8'h00 for the 0000_xxxx ops. -> WB.
- WB: ext_reg<=ext, cb_flag<=cb. acc<=acc_out, except CMP, where acc is unchanged. -> FETCH.
- Outside EXEC, opcode=8'h00 and data_reg=8'h00; acc_to_alu always mirrors acc.
- HALT: halted=1, imem_req=0, no state change until rst.

## Timing
- Reset values: pc=0, acc=0, ext_reg=0, cb_flag=0, all RF=0, IR=0, state=FETCH, imem_req=0 during the reset cycle, opcode=0, data_reg=0, halted=0.
- FETCH lasts at least 1 cycle. imem_valid in the same cycle as imem_req is accepted.
- Latency with zero-wait memory:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - MOV/NOP: 2 cycles.
- ALU is registered: opcode and operands are stable for the whole EXEC cycle; ALU outputs are sampled on the WB-ending edge.
- Reset mid-instruction: everything returns to reset values next edge; partial writes are not committed. A fetch in flight is abandoned, and imem_valid arriving while imem_req=0 is ignored.
- pc=2^PC_W-1 fetch: pc wraps to 0, no flag.
- Back-to-back writes to RF/acc have no hazards; the sequencer is non-pipelined.

## Structure
- Shared package cpu_pkg: opcode localparams (OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_XOR, OP_CMP, OP_MOVRA, OP_MOVAR, OP_LSL, OP_LSR, OP_INC, OP_DEC, OP_NOP, OP_HLT), state encoding, and an is_alu_op helper. The ALU consumes the same constants.
- Sub-module reg_file: RF_DEPTH x 8, one sync write port, one async read port, synchronous reset to 0.

## Test plan
- Reset then program {1001_0000, 0001_0000, ...} with R0=0: acc=0. Then preload via MOV: acc 10 -> MOV R1<-acc; set acc=15 via INC sequence -> ADD R1: acc=25 after WB, cb=0, 4 cycles.
- MUL: acc=7, R2=6, opcode 0011_0010 -> acc=42, ext_reg=0. With acc=200, R2=2 -> acc=144, ext_reg=1.
- CMP acc=50, R3=100 -> acc stays 50, cb_flag=1. INC from acc=255 -> acc=0, cb_flag per ALU.
- imem_valid delayed 3 cycles -> imem_req held and imem_addr stable; instruction executes correctly. HLT -> halted=1, imem_req=0, pc frozen.
- Assert rst during EXEC of ADD -> acc/pc/RF return to 0 and no write-back occurs. pc at 255 fetches NOP -> pc=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants, sequencer state encoding and decode helper for the
// sequencer/ALU pair.
package cpu_pkg;

    // Register-operand ops are identified by the upper nibble alone.
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_MUL   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_CMP   = 4'h7;
    localparam logic [3:0] OP_MOVRA = 4'h8;
    localparam logic [3:0] OP_MOVAR = 4'h9;

    // Operand-less ops are full-byte encodings.
    localparam logic [7:0] OP_LSL = 8'h01;
    localparam logic [7:0] OP_LSR = 8'h02;
    localparam logic [7:0] OP_INC = 8'h06;
    localparam logic [7:0] OP_DEC = 8'h07;
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_HLT = 8'hFF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } seq_state_t;

    function automatic logic is_alu_op(input logic [7:0] instr);
        logic result;
        result = 1'b0;
        case (instr[7:4])
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_XOR, OP_CMP: result = 1'b1;
            4'h0: result = (instr == OP_LSL) || (instr == OP_LSR) ||
                           (instr == OP_INC) || (instr == OP_DEC);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/reg_file.sv
// General register file: one synchronous write port, one combinational read
// port, every entry cleared by reset.
module reg_file #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] rd_array [DEPTH];

    // Entries are discrete flops so that reset can clear the whole file at once.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    entry_reg <= wdata;
                end
            end

            assign rd_array[gi] = entry_reg;
        end
    endgenerate

    assign rdata = rd_array[raddr];

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back controller that drives the ALU
// and owns the accumulator, flags, program counter and register file.
module exec_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RF_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic [7:0]      imem_data,
    input  logic            imem_valid,
    output logic [7:0]      opcode,
    output logic [7:0]      acc_to_alu,
    output logic [7:0]      data_reg,
    input  logic [7:0]      acc_out,
    input  logic [7:0]      ext,
    input  logic            cb,
    output logic [7:0]      acc,
    output logic [7:0]      ext_reg,
    output logic            cb_flag,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam int RF_AW = $clog2(RF_DEPTH);

    seq_state_t      state_reg, state_next;
    logic [7:0]      ir_reg, ir_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [7:0]      acc_reg, acc_next;
    logic [7:0]      ext_latch_reg, ext_latch_next;
    logic            cb_reg, cb_next;

    logic            rf_we;
    logic [7:0]      rf_rdata;
    logic            fetch_req;
    logic [7:0]      opcode_drive;
    logic [7:0]      data_drive;

    reg_file #(
        .DEPTH (RF_DEPTH),
        .WIDTH (8)
    ) u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (ir_reg[RF_AW-1:0]),
        .wdata (acc_reg),
        .raddr (ir_reg[RF_AW-1:0]),
        .rdata (rf_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            ir_reg        <= 8'h00;
            pc_reg        <= '0;
            acc_reg       <= 8'h00;
            ext_latch_reg <= 8'h00;
            cb_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ir_reg        <= ir_next;
            pc_reg        <= pc_next;
            acc_reg       <= acc_next;
            ext_latch_reg <= ext_latch_next;
            cb_reg        <= cb_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ir_next        = ir_reg;
        pc_next        = pc_reg;
        acc_next       = acc_reg;
        ext_latch_next = ext_latch_reg;
        cb_next        = cb_reg;
        rf_we          = 1'b0;
        fetch_req      = 1'b0;
        opcode_drive   = 8'h00;
        data_drive     = 8'h00;

        case (state_reg)
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (imem_valid) begin
                    ir_next    = imem_data;
                    pc_next    = pc_reg + PC_W'(1);
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_alu_op(ir_reg)) begin
                    state_next = ST_EXEC;
                end else if (ir_reg[7:4] == OP_MOVRA) begin
                    rf_we      = 1'b1;
                    state_next = ST_FETCH;
                end else if (ir_reg[7:4] == OP_MOVAR) begin
                    acc_next   = rf_rdata;
                    state_next = ST_FETCH;
                end else if (ir_reg == OP_HLT) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_EXEC: begin
                opcode_drive = ir_reg;
                // Shift/increment ops carry no register operand.
                data_drive   = (ir_reg[7:4] != 4'h0) ? rf_rdata : 8'h00;
                state_next   = ST_WB;
            end
            ST_WB: begin
                ext_latch_next = ext;
                cb_next        = cb;
                if (ir_reg[7:4] != OP_CMP) begin
                    acc_next = acc_out;
                end
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Outputs to memory and ALU read as idle for the whole reset cycle.
    assign imem_req   = fetch_req & ~rst;
    assign opcode     = rst ? 8'h00 : opcode_drive;
    assign data_reg   = rst ? 8'h00 : data_drive;
    assign imem_addr  = pc_reg;
    assign acc_to_alu = acc_reg;
    assign acc        = acc_reg;
    assign ext_reg    = ext_latch_reg;
    assign cb_flag    = cb_reg;
    assign pc         = pc_reg;
    assign halted     = (state_reg == ST_HALT);

endmodule
